// File: rtl/sipo_word_assembler_pkg.sv
// Shared types and constants for the serial-in word assembler.
// Optional parity checking is enabled by SIPO_WORD_ASSEMBLER_PARITY_CHECK_EN.
package sipo_word_assembler_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_e;

  localparam int unsigned WORD_COUNT_W = 8;

  function automatic int unsigned cnt_width(input int unsigned data_width);
    return $clog2(data_width + 1);
  endfunction

endpackage

// File: rtl/sipo_parity_accumulator.sv
// Running XOR of the data bits of the word being assembled; reloaded with the
// first bit of each new word. Used only with SIPO_WORD_ASSEMBLER_PARITY_CHECK_EN.
module sipo_parity_accumulator (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic start_i,
  input  logic bit_valid_i,
  input  logic bit_i,
  output logic parity_o
);

  logic acc_q, acc_d;

  always_comb begin
    acc_d = acc_q;
    if (start_i) begin
      acc_d = bit_i;
    end else if (bit_valid_i) begin
      acc_d = acc_q ^ bit_i;
    end
  end

  always_ff @(negedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign parity_o = acc_q;

endmodule

// File: rtl/sipo_word_assembler.sv
// Collects qualified serial bits into DATA_WIDTH-bit words and publishes each
// with a one-cycle load strobe. Define SIPO_WORD_ASSEMBLER_PARITY_CHECK_EN for even-parity checking.
module sipo_word_assembler
  import sipo_word_assembler_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 4,
  parameter bit          MSB_FIRST  = 1'b0
) (
  input  logic                    Clk_In,
  input  logic                    Reset_In,
  input  logic                    Enable_In,
  input  logic                    Serial_Valid_In,
  input  logic                    Serial_Data_In,
  input  logic                    Frame_Start_In,
  output logic [DATA_WIDTH-1:0]   Parallel_Data_Out,
  output logic                    Load_Data_Signal_Out,
  output logic                    Busy_Out,
  output logic [WORD_COUNT_W-1:0] Word_Count_Out,
  output logic                    Parity_Error_Out
);

  localparam int unsigned CW = cnt_width(DATA_WIDTH);

  typedef logic [DATA_WIDTH-1:0] word_t;

  function automatic word_t place_bit(input word_t w, input logic [CW-1:0] idx, input logic b);
    word_t       r;
    int unsigned pos;
    r   = w;
    pos = MSB_FIRST ? (DATA_WIDTH - 1 - 32'(idx)) : 32'(idx);
    for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
      if (i == pos) r[i] = b;
    end
    return r;
  endfunction

  state_e                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  word_t                   shreg_q, shreg_d;
  word_t                   data_q, data_d;
  logic                    load_q, load_d;
  logic [WORD_COUNT_W-1:0] count_q, count_d;

  logic  accept;
  logic  start_word;
  word_t new_word;

  assign accept     = Enable_In && Serial_Valid_In;
  assign start_word = accept && (Frame_Start_In || (state_q == IDLE));
  // A starting bit always lands at index 0 of a cleared word.
  assign new_word   = start_word ? place_bit('0, '0, Serial_Data_In)
                                 : place_bit(shreg_q, cnt_q, Serial_Data_In);

`ifdef SIPO_WORD_ASSEMBLER_PARITY_CHECK_EN
  logic perr_q, perr_d;
  logic par_acc;

  sipo_parity_accumulator u_parity (
    .clk_i       (Clk_In),
    .rst_ni      (Reset_In),
    .start_i     (start_word),
    .bit_valid_i (accept && !Frame_Start_In && (state_q == SHIFT)),
    .bit_i       (Serial_Data_In),
    .parity_o    (par_acc)
  );
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    data_d  = data_q;
    load_d  = 1'b0;
    count_d = count_q;
`ifdef SIPO_WORD_ASSEMBLER_PARITY_CHECK_EN
    perr_d  = 1'b0;
`endif
    if (Enable_In) begin
      if (Frame_Start_In && !Serial_Valid_In) begin
        state_d = IDLE;
        cnt_d   = '0;
        shreg_d = '0;
      end else if (start_word) begin
        state_d = SHIFT;
        cnt_d   = CW'(1);
        shreg_d = new_word;
      end else if (accept) begin
        case (state_q)
          SHIFT: begin
            shreg_d = new_word;
            cnt_d   = cnt_q + CW'(1);
            if (cnt_q == CW'(DATA_WIDTH - 1)) begin
`ifdef SIPO_WORD_ASSEMBLER_PARITY_CHECK_EN
              state_d = PARITY;
`else
              state_d = IDLE;
              cnt_d   = '0;
              shreg_d = '0;
              data_d  = new_word;
              load_d  = 1'b1;
              count_d = count_q + WORD_COUNT_W'(1);
`endif
            end
          end
`ifdef SIPO_WORD_ASSEMBLER_PARITY_CHECK_EN
          PARITY: begin
            state_d = IDLE;
            cnt_d   = '0;
            shreg_d = '0;
            if (par_acc ^ Serial_Data_In) begin
              perr_d = 1'b1;
            end else begin
              data_d  = shreg_q;
              load_d  = 1'b1;
              count_d = count_q + WORD_COUNT_W'(1);
            end
          end
`endif
          default: ;
        endcase
      end
    end
  end

  always_ff @(negedge Clk_In or negedge Reset_In) begin
    if (!Reset_In) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shreg_q <= '0;
      data_q  <= '0;
      load_q  <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
      data_q  <= data_d;
      load_q  <= load_d;
      count_q <= count_d;
    end
  end

`ifdef SIPO_WORD_ASSEMBLER_PARITY_CHECK_EN
  always_ff @(negedge Clk_In or negedge Reset_In) begin
    if (!Reset_In) begin
      perr_q <= 1'b0;
    end else begin
      perr_q <= perr_d;
    end
  end

  assign Parity_Error_Out = perr_q;
`else
  assign Parity_Error_Out = 1'b0;
`endif

  assign Parallel_Data_Out    = data_q;
  assign Load_Data_Signal_Out = load_q;
  assign Busy_Out             = (state_q != IDLE);
  assign Word_Count_Out       = count_q;

endmodule

// File: tb/tb_sipo_word_assembler.sv
// Scoreboard bench driving LSB-first and MSB-first assemblers from one serial stream.
module tb_sipo_word_assembler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, en, vld, sd, fs;
  logic [3:0] pd_l, pd_m;
  logic       ld_l, ld_m, busy_l, busy_m, perr_l, perr_m;
  logic [7:0] wc_l, wc_m;

  sipo_word_assembler #(.DATA_WIDTH(4), .MSB_FIRST(1'b0)) dut_lsb (
    .Clk_In(clk), .Reset_In(rst_n), .Enable_In(en), .Serial_Valid_In(vld),
    .Serial_Data_In(sd), .Frame_Start_In(fs), .Parallel_Data_Out(pd_l),
    .Load_Data_Signal_Out(ld_l), .Busy_Out(busy_l), .Word_Count_Out(wc_l),
    .Parity_Error_Out(perr_l)
  );

  sipo_word_assembler #(.DATA_WIDTH(4), .MSB_FIRST(1'b1)) dut_msb (
    .Clk_In(clk), .Reset_In(rst_n), .Enable_In(en), .Serial_Valid_In(vld),
    .Serial_Data_In(sd), .Frame_Start_In(fs), .Parallel_Data_Out(pd_m),
    .Load_Data_Signal_Out(ld_m), .Busy_Out(busy_m), .Word_Count_Out(wc_m),
    .Parity_Error_Out(perr_m)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0] lsb;
    logic [3:0] msb;
    int         cyc;
  } exp_t;

  exp_t       wq[$];
  int         errq[$];
  int         cyc = 0;
  int         n_str = 0;
  logic [7:0] exp_cnt = 8'd0;
  logic       prev_ld = 1'b0;

  initial forever begin
    @(negedge clk);
    cyc++;
  end

  // Scoreboard: every strobe must match the oldest expected word in value, cycle and count.
  initial forever begin
    exp_t e;
    @(posedge clk);
    if (ld_l || ld_m) begin
      n_str++;
      check("ld_lsb", ld_l, 1);
      check("ld_msb", ld_m, 1);
      check("strobe_width", prev_ld, 0);
      if (wq.size() == 0) begin
        check("extra_strobe", ld_l | ld_m, 0);
      end else begin
        e = wq.pop_front();
        exp_cnt++;
        check("data_lsb", pd_l, e.lsb);
        check("data_msb", pd_m, e.msb);
        check("latency", cyc, e.cyc);
        check("count_lsb", wc_l, exp_cnt);
        check("count_msb", wc_m, exp_cnt);
      end
    end
    if (perr_l || perr_m) begin
      check("perr_lsb", perr_l, 1);
      check("perr_msb", perr_m, 1);
      if (errq.size() == 0) check("extra_perr", perr_l | perr_m, 0);
      else                  check("perr_cycle", cyc, errq.pop_front());
    end
    prev_ld = ld_l | ld_m;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  function automatic logic [3:0] rev4(input logic [3:0] s);
    logic [3:0] r;
    for (int i = 0; i < 4; i++) r[i] = s[3-i];
    return r;
  endfunction

  task automatic drive(input logic e, input logic v, input logic b, input logic f);
    @(posedge clk);
    en = e; vld = v; sd = b; fs = f;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  // seq[0] is the first bit on the wire; called right after the last data bit.
  task automatic expect_word(input logic [3:0] seq);
`ifdef SIPO_WORD_ASSEMBLER_PARITY_CHECK_EN
    drive(1'b1, 1'b1, ^seq, 1'b0);
`endif
    wq.push_back('{lsb: seq, msb: rev4(seq), cyc: cyc + 1});
  endtask

  task automatic send_word(input logic [3:0] seq);
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, seq[i], 1'b0);
    expect_word(seq);
  endtask

  task automatic do_reset();
    @(posedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    exp_cnt = 8'd0;
    rst_n   = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; vld = 1'b0; sd = 1'b0; fs = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_data", pd_l, 0);
    check("rst_load", ld_l, 0);
    check("rst_busy", busy_l, 0);
    check("rst_count", wc_l, 0);
    check("rst_perr", perr_l, 0);
    @(posedge clk);
    rst_n = 1'b1;

    // Bits 1,0,1,1: LSB-first 4'b1101, MSB-first 4'b1011.
    send_word(4'b1101);
    idle(3);
    check("count_one", wc_l, 1);
    check("word_1101", pd_l, 4'b1101);
    check("word_1011", pd_m, 4'b1011);

    // 1,1 discarded by a frame start carrying 0, then 0,1,0.
    drive(1'b1, 1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b1);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    expect_word(4'b0100);
    idle(3);

    // Valid gaps and enable-low cycles with ignored data mid-word.
    drive(1'b1, 1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 1'b1, 1'b1);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    check("busy_mid", busy_l, 1);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 1'b0);
    expect_word(4'b1001);
    idle(3);

    // Frame start without a bit aborts the partial word.
    drive(1'b1, 1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    check("busy_abort", busy_l, 0);
    send_word(4'b0011);
    idle(3);

    // Reset mid-word.
    drive(1'b1, 1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    idle(1);
    check("busy_before_rst", busy_l, 1);
    rst_n = 1'b0;
    #1;
    check("mrst_data_l", pd_l, 0);
    check("mrst_data_m", pd_m, 0);
    check("mrst_load", ld_l, 0);
    check("mrst_busy", busy_l, 0);
    check("mrst_count", wc_l, 0);
    check("mrst_perr", perr_l, 0);
    exp_cnt = 8'd0;
    @(posedge clk);
    rst_n = 1'b1;
    send_word(4'b0110);
    idle(3);
    check("after_rst_count", wc_l, 1);

`ifdef SIPO_WORD_ASSEMBLER_PARITY_CHECK_EN
    send_word(4'b1101);
    idle(2);
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, (i == 1) ? 1'b0 : 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    errq.push_back(cyc + 1);
    idle(3);
    check("perr_hold_data", pd_l, 4'b1101);
    check("perr_hold_count", wc_l, 2);
`endif

    // 256 back-to-back words from a cleared counter wrap it back to 0.
    do_reset();
    n_str = 0;
    for (int w = 0; w < 256; w++) send_word(4'($urandom_range(0, 15)));
    idle(4);
    check("strobe_total", n_str, 256);
    check("wrap_count", wc_l, 0);
    check("wrap_count_m", wc_m, 0);
    check("queue_empty", wq.size(), 0);
    check("errq_empty", errq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sipo_word_assembler.md
# sipo_word_assembler

Serial-in word assembler that sits directly upstream of the 4-bit parallel-in-parallel-out register stage. It collects a qualified serial bit stream into DATA_WIDTH-bit words. For each completed word it presents the word on a parallel bus together with a one-cycle load strobe that drives the downstream stage's load input. Optional per-word parity checking drops corrupted words before they reach the register.

## Interface

Parameters:
- DATA_WIDTH, 4, bits per word; legal range 2..16.
- MSB_FIRST, 0, 0 = first received bit lands in bit 0; 1 = first received bit lands in bit DATA_WIDTH-1.

Ports:
- Clk_In  input  1  single clock; all state updates on the falling edge.
- Reset_In  input  1  asynchronous, active-low reset.
- Enable_In  input  1  high = bits may be accepted; low = freeze the accept path.
- Serial_Valid_In  input  1  Serial_Data_In is valid this cycle.
- Serial_Data_In  input  1  serial bit.
- Frame_Start_In  input  1  discard any partial word; the bit accepted with it becomes bit 0 of a new word.
- Parallel_Data_Out  output  DATA_WIDTH  last published word; held until the next publish.
- Load_Data_Signal_Out  output  1  one-cycle strobe; Parallel_Data_Out is valid for the downstream stage to load.
- Busy_Out  output  1  high while a partial word (or pending parity bit) is held.
- Word_Count_Out  output  8  count of published words; wraps 255 -> 0.
- Parity_Error_Out  output  1  one-cycle pulse when a word is dropped for bad parity.

## Operation

- Bit acceptance: a bit is accepted at a falling edge when Enable_In = 1 and Serial_Valid_In = 1.
- State machine: IDLE, SHIFT, PARITY. PARITY exists only with PARITY_CHECK_EN.
- IDLE -> SHIFT: on the first accepted bit. The bit counter becomes 1.
- SHIFT: each accepted bit is placed per MSB_FIRST and increments the counter. When the DATA_WIDTH-th bit is accepted, the next state is PARITY if the macro is defined, else the word is published and the state returns to IDLE.
- Publish actions:
  - Parallel_Data_Out <= assembled word.
  - Load_Data_Signal_Out = 1 for the following cycle.
  - Word_Count_Out increments by 1.
- Back-to-back words: a bit accepted during the strobe cycle starts the next word with no bubble.
- Frame_Start_In with an accepted bit: the partial word is discarded and that bit becomes bit 0, counter = 1. Frame_Start_In without an accepted bit: the partial word is discarded, state -> IDLE, counter = 0.
- Enable_In = 0 holds the state, counter and partial word. Any already-registered strobe still completes.
- Reset_In low, including mid-word:
  - state IDLE, counter 0, partial word cleared.
  - Parallel_Data_Out = 0, Load_Data_Signal_Out = 0, Busy_Out = 0, Word_Count_Out = 0, Parity_Error_Out = 0.

## Timing

- Latency: the strobe is high in the cycle between the falling edge that accepts the last bit (or the parity bit) and the next falling edge. The downstream stage samples at that next edge.
- Data stability: Parallel_Data_Out changes only on the publish edge. It is therefore stable for the whole strobe cycle and the sampling edge.
- Strobe width: always exactly one cycle. Minimum word period is DATA_WIDTH cycles, or DATA_WIDTH+1 with parity.
- Busy_Out is combinational from state: high in SHIFT and PARITY, low in IDLE.

## Configuration

- Macro: SIPO_WORD_ASSEMBLER_PARITY_CHECK_EN.
- Defined:
  - After the data bits, one further accepted bit is taken as the even-parity bit.
  - XOR of data bits and parity bit = 0: publish as normal.
  - XOR = 1: no publish, no strobe, no count increment; Parallel_Data_Out unchanged; Parity_Error_Out pulses for one cycle.
  - Frame_Start_In during PARITY behaves as in SHIFT.
- Undefined: the PARITY state and parity logic are absent, and Parity_Error_Out is tied 0.

## Structure

- Shared package sipo_word_assembler_pkg holds:
  - the state enum (IDLE, SHIFT, PARITY);
  - the Word_Count_Out width constant (8);
  - the counter width function clog2(DATA_WIDTH+1).
- One sub-module is natural: sipo_parity_accumulator, a running XOR cleared on word start. It is instantiated only under the macro.

## Test plan

- LSB-first: MSB_FIRST=0, bits 1,0,1,1 on consecutive cycles -> Parallel_Data_Out = 4'b1101; strobe high exactly one cycle after the 4th bit edge; Word_Count_Out = 1.
- MSB-first: MSB_FIRST=1, same bits -> Parallel_Data_Out = 4'b1011.
- Framing and gaps:
  - Bits 1,1, then Frame_Start_In with bit 0, then 0,1,0 -> word 4'b0100; the first two bits are discarded.
  - Serial_Valid_In gaps and Enable_In low mid-word -> same result, no extra strobes.
- Reset mid-word: assert Reset_In low after 2 bits -> all outputs 0. After release, a full 4-bit word 4'b0110 publishes correctly.
- Parity (macro on):
  - Data 1,0,1,1 + parity 1 -> publish 4'b1101.
  - Data 1,0,1,1 + parity 0 -> Parity_Error_Out pulse, no strobe, Parallel_Data_Out holds its previous value.
- Throughput and wrap: 256 back-to-back words -> 256 strobes, each one cycle wide; Word_Count_Out wraps to 0.
